// File: rtl/imem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// Holds the FSM state encoding, the fault data word and the address-fault rule.
package imem_responder_pkg;

   typedef enum logic [1:0] {
      IMEM_IDLE = 2'd0,
      IMEM_WAIT = 2'd1,
      IMEM_RESP = 2'd2
   } imem_state_e;

   localparam logic [31:0] IMEM_FAULT_DATA = 32'h0;

   // Wide enough for the largest supported wait-state count (15).
   localparam int IMEM_CNT_W = 4;

   // A byte address faults when it is not word aligned or lies past the array.
   function automatic logic addr_fault(input logic [31:0] addr, input int depth_words);
      logic [32:0] limit;
      limit = 33'(depth_words) << 2;
      return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
   endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Instruction word storage: one synchronous write port, one asynchronous read port.
// Contents survive reset; the program loader is the only writer.
module imem_responder_array #(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = 6
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one word fetch at a time and returns it
// after WAIT_CYCLES wait states; a load port writes the array directly.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IMEM_IDLE | ready for a fetch; word and fault flag captured on accept
//   IMEM_WAIT | counting wait states down to zero
//   IMEM_RESP | response held on rsp_* until the initiator takes it
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   input  logic        wr_en,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [IMEM_CNT_W-1:0] WAIT_LOAD =
      (WAIT_CYCLES > 0) ? IMEM_CNT_W'(WAIT_CYCLES - 1) : '0;

   imem_state_e           state_q, state_d;
   logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]           rsp_data_q;
   logic                  rsp_err_q;
   logic                  accept;
   logic                  req_fault;
   logic                  wr_ok;
   logic [AW-1:0]         rd_idx;
   logic [AW-1:0]         wr_idx;
   logic [31:0]           rd_word;

   assign rd_idx    = req_addr[AW+1:2];
   assign wr_idx    = wr_addr[AW+1:2];
   assign req_fault = addr_fault(req_addr, DEPTH_WORDS);
   assign wr_ok     = wr_en && !addr_fault(wr_addr, DEPTH_WORDS);

   imem_responder_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IMEM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IMEM_IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = IMEM_RESP;
               end else begin
                  state_d = IMEM_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         IMEM_WAIT: begin
            if (cnt_q == '0) begin
               state_d = IMEM_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         IMEM_RESP: begin
            if (rsp_ready) begin
               state_d = IMEM_IDLE;
            end
         end
         default: begin
            state_d = IMEM_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The word is captured on accept, so a load-port write on the same edge
   // or later never alters a pending response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (accept) begin
         rsp_data_q <= req_fault ? IMEM_FAULT_DATA : rd_word;
         rsp_err_q  <= req_fault;
      end
   end

   assign req_ready = (state_q == IMEM_IDLE);
   assign rsp_valid = (state_q == IMEM_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (WAIT_CYCLES 2, 0, 1) checked
// against a word-array reference model of the fetch and load-port rules.
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [3];
   logic        req_ready [3];
   logic [31:0] req_addr  [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_data  [3];
   logic        rsp_err   [3];
   logic        wr_en     [3];
   logic [31:0] wr_addr   [3];
   logic [31:0] wr_data   [3];

   logic [31:0] mem_m [3][64];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      imem_responder #(
         .DEPTH_WORDS (64),
         .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 0 : 1))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_addr  (req_addr[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_ready (rsp_ready[g]),
         .rsp_data  (rsp_data[g]),
         .rsp_err   (rsp_err[g]),
         .wr_en     (wr_en[g]),
         .wr_addr   (wr_addr[g]),
         .wr_data   (wr_data[g])
      );
   end

   function automatic int wc(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 0 : 1);
   endfunction

   function automatic bit is_fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'd256);
   endfunction

   function automatic logic [31:0] exp_word(input int i, input logic [31:0] a);
      if (is_fault(a)) return 32'h0;
      return mem_m[i][a[7:2]];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input int i, input logic [31:0] a, input logic [31:0] d);
      wr_en[i]   = 1'b1;
      wr_addr[i] = a;
      wr_data[i] = d;
      step();
      wr_en[i] = 1'b0;
      if (!is_fault(a)) mem_m[i][a[7:2]] = d;
   endtask

   task automatic do_fetch(input int i, input logic [31:0] a, input int stall,
                           input bit pre_ready, input bit acc_wr,
                           input logic [31:0] wa, input logic [31:0] wd,
                           input string tag);
      logic [31:0] exp_d;
      bit          exp_e;
      int          n;
      exp_d = exp_word(i, a);
      exp_e = is_fault(a);
      n_checks++;
      if (req_ready[i] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_before: got %b want 1", tag, req_ready[i]);
      end
      req_valid[i] = 1'b1;
      req_addr[i]  = a;
      rsp_ready[i] = pre_ready;
      if (acc_wr) begin
         wr_en[i]   = 1'b1;
         wr_addr[i] = wa;
         wr_data[i] = wd;
      end
      step();
      req_valid[i] = 1'b0;
      req_addr[i]  = $urandom;
      wr_en[i]     = 1'b0;
      if (acc_wr && !is_fault(wa)) mem_m[i][wa[7:2]] = wd;
      n = 1;
      while (rsp_valid[i] !== 1'b1 && n < 40) begin
         n_checks++;
         if (req_ready[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_in_wait: got %b want 0", tag, req_ready[i]);
         end
         step();
         n++;
      end
      n_checks++;
      if (n != wc(i) + 1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", tag, n, wc(i) + 1);
      end
      for (int s = 0; s <= stall; s++) begin
         n_checks++;
         if (rsp_valid[i] !== 1'b1 || rsp_data[i] !== exp_d || rsp_err[i] !== exp_e
             || req_ready[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s response[%0d]: got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                     tag, s, rsp_valid[i], rsp_data[i], rsp_err[i], req_ready[i], exp_d, exp_e);
         end
         if (s < stall) begin
            rsp_ready[i] = 1'b0;
            step();
         end
      end
      rsp_ready[i] = 1'b1;
      step();
      rsp_ready[i] = 1'b0;
      n_checks++;
      if (rsp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s after_handshake: got v=%b rdy=%b want v=0 rdy=1",
                  tag, rsp_valid[i], req_ready[i]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rsp_valid[i] !== 1'b0 || rsp_data[i] !== 32'h0 || rsp_err[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs[%0d]: got v=%b d=%h e=%b want 0 0 0",
                     i, rsp_valid[i], rsp_data[i], rsp_err[i]);
         end
      end
      step();
      rst = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (req_ready[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready[%0d]: got %b want 1", i, req_ready[i]);
         end
      end
   endtask

   task automatic load_all();
      for (int k = 0; k < 64; k++) begin
         for (int i = 0; i < 3; i++) begin
            wr_en[i]     = 1'b1;
            wr_addr[i]   = 32'(k * 4);
            wr_data[i]   = $urandom;
            mem_m[i][k]  = wr_data[i];
         end
         step();
      end
      for (int i = 0; i < 3; i++) wr_en[i] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         write_word(i, 32'h0, 32'h004180e7);
         write_word(i, 32'hC, 32'hffc200e7);
      end
   endtask

   task automatic test_basic();
      do_fetch(0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 32'h0, "basic_0x0");
      do_fetch(0, 32'hC, 0, 1'b1, 1'b0, 32'h0, 32'h0, "basic_0xC");
      n_checks++;
      if (mem_m[0][0] !== 32'h004180e7 || mem_m[0][3] !== 32'hffc200e7) begin
         n_fail++;
         $display("FAIL model_load: got %h %h", mem_m[0][0], mem_m[0][3]);
      end
   endtask

   task automatic test_stall();
      do_fetch(1, 32'hC, 5, 1'b0, 1'b0, 32'h0, 32'h0, "stall_w0");
   endtask

   task automatic test_fault();
      do_fetch(1, 32'h2, 0, 1'b1, 1'b0, 32'h0, 32'h0, "fault_misaligned");
      do_fetch(1, 32'h100, 0, 1'b1, 1'b0, 32'h0, 32'h0, "fault_range");
      do_fetch(1, 32'hFFFF_FFFC, 0, 1'b0, 1'b0, 32'h0, 32'h0, "fault_high");
      write_word(1, 32'h100, 32'hDEAD_BEEF);
      write_word(1, 32'h2, 32'hBAD0_0002);
      write_word(1, 32'h101, 32'hBAD0_0101);
      write_word(1, 32'h4000_0000, 32'hBAD0_4000);
      for (int k = 0; k < 64; k++) begin
         do_fetch(1, 32'(k * 4), 0, 1'b1, 1'b0, 32'h0, 32'h0, "sweep");
      end
   endtask

   task automatic test_same_cycle_write();
      write_word(0, 32'hC, 32'h11111111);
      do_fetch(0, 32'hC, 1, 1'b0, 1'b1, 32'hC, 32'h22222222, "accept_write_old");
      n_checks++;
      if (mem_m[0][3] !== 32'h22222222) begin
         n_fail++;
         $display("FAIL model_write: got %h want 22222222", mem_m[0][3]);
      end
      do_fetch(0, 32'hC, 0, 1'b1, 1'b0, 32'h0, 32'h0, "accept_write_new");
   endtask

   task automatic test_reset_mid_wait();
      bit seen;
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h0;
      step();
      req_valid[0] = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (rsp_valid[0] !== 1'b0 || rsp_data[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_wait: got v=%b d=%h e=%b want 0 0 0",
                  rsp_valid[0], rsp_data[0], rsp_err[0]);
      end
      step();
      step();
      rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid[0] !== 1'b0) seen = 1'b1;
         step();
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL dropped_fetch: got rsp_valid=1 want never");
      end
      n_checks++;
      if (req_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_reset: got %b want 1", req_ready[0]);
      end
      do_fetch(0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 32'h0, "post_reset_0x0");
   endtask

   task automatic test_back_to_back();
      int          acc_cyc [4];
      logic [31:0] got_d   [4];
      logic        got_e   [4];
      int          idx;
      int          nrsp;
      int          cyc;
      bit          acc;
      idx  = 0;
      nrsp = 0;
      cyc  = 0;
      req_valid[2] = 1'b1;
      req_addr[2]  = 32'h0;
      rsp_ready[2] = 1'b1;
      while ((idx < 4 || nrsp < 4) && cyc < 60) begin
         acc = req_valid[2] && req_ready[2];
         if (rsp_valid[2] === 1'b1 && nrsp < 4) begin
            got_d[nrsp] = rsp_data[2];
            got_e[nrsp] = rsp_err[2];
            nrsp++;
         end
         step();
         if (acc) begin
            acc_cyc[idx] = cyc;
            idx++;
            if (idx < 4) req_addr[2] = 32'(idx * 4);
            else req_valid[2] = 1'b0;
         end
         cyc++;
      end
      rsp_ready[2] = 1'b0;
      req_valid[2] = 1'b0;
      n_checks++;
      if (idx != 4 || nrsp != 4) begin
         n_fail++;
         $display("FAIL b2b_count: got acc=%0d rsp=%0d want 4 4", idx, nrsp);
      end else begin
         for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
               n_fail++;
               $display("FAIL b2b_spacing[%0d]: got %0d want 3", k, acc_cyc[k] - acc_cyc[k-1]);
            end
         end
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got_d[k] !== mem_m[2][k] || got_e[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_data[%0d]: got %h e=%b want %h e=0",
                        k, got_d[k], got_e[k], mem_m[2][k]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] wa;
      bit          aw;
      for (int i = 0; i < 3; i++) begin
         for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 4) != 0) a = 32'($urandom_range(0, 63) * 4);
            else a = $urandom;
            aw = ($urandom_range(0, 3) == 0);
            wa = ($urandom_range(0, 1) == 0) ? a : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0)
               write_word(i, 32'($urandom_range(0, 63) * 4), $urandom);
            do_fetch(i, a, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     aw, wa, $urandom, "rand");
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         req_valid[i] = 1'b0;
         req_addr[i]  = 32'h0;
         rsp_ready[i] = 1'b0;
         wr_en[i]     = 1'b0;
         wr_addr[i]   = 32'h0;
         wr_data[i]   = 32'h0;
      end
      test_reset();
      load_all();
      test_basic();
      test_stall();
      test_fault();
      test_same_cycle_write();
      test_reset_mid_wait();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
